// File: rtl/debug_pkg.sv
// Shared command codes, dump header byte and FSM state encoding for the debug dumper.
`timescale 1ns/1ps
package debug_pkg;

    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_SNAP = 3'd3,
        ST_HDR  = 3'd4,
        ST_DATA = 3'd5,
        ST_CSUM = 3'd6
    } state_t;

endpackage

// File: rtl/debug_dumper_if.sv
// Host command channel and dump byte stream grouped as one bundle.
`timescale 1ns/1ps
interface debug_dumper_if;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output cmd_byte, cmd_valid, tx_ready,
        input  cmd_ready, tx_data, tx_valid
    );

    modport slave (
        input  cmd_byte, cmd_valid, tx_ready,
        output cmd_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/dbg_byte_ser.sv
// Snapshot register plus MSB-first byte walker; presents one byte at a time with valid/ready.
`timescale 1ns/1ps
module dbg_byte_ser #(
    parameter int N_WORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [32*N_WORDS-1:0]  snap_data,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int N_BYTES = N_WORDS * 4;
    localparam int IDX_W   = $clog2(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BYTES - 1);
    localparam logic [IDX_W-1:0] LANE_FLIP = IDX_W'(3);

    logic [32*N_WORDS-1:0] snap_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic                  active_reg;
    logic [IDX_W-1:0]      byte_pos;

    // Flipping the two low index bits turns word-order/MSB-first into a flat LSB byte offset.
    assign byte_pos  = idx_reg ^ LANE_FLIP;
    assign out_data  = snap_reg[{byte_pos, 3'b000} +: 8];
    assign out_valid = active_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_reg   <= '0;
            idx_reg    <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            snap_reg   <= snap_data;
            idx_reg    <= '0;
            active_reg <= 1'b1;
        end else if (active_reg && out_ready) begin
            // The last byte retires the walker rather than wrapping the index.
            if (idx_reg == LAST_IDX) begin
                active_reg <= 1'b0;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_dumper.sv
// Debug command FSM: run/halt/step control of a pipeline and framed snapshot dump (header, data, XOR).
`timescale 1ns/1ps
module debug_dumper
    import debug_pkg::*;
#(
    parameter int N_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    debug_dumper_if.slave         bus,
    input  logic [32*N_WORDS-1:0] snap_data,
    output logic                  pipe_en,
    output logic                  busy
);
    state_t     state_reg, state_next;
    logic       cmd_ready_reg, pipe_en_reg, tx_valid_reg;
    logic [7:0] tx_data_reg, csum_reg;
    logic       cmd_fire, tx_fire;
    logic [7:0] ser_data;
    logic       ser_valid, ser_ready, ser_load;

    assign cmd_fire      = bus.cmd_valid && cmd_ready_reg;
    assign tx_fire       = tx_valid_reg && bus.tx_ready;
    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.tx_valid  = tx_valid_reg;
    assign bus.tx_data   = tx_data_reg;
    assign pipe_en       = pipe_en_reg;
    assign busy          = !((state_reg == ST_IDLE) || (state_reg == ST_RUN));

    assign ser_load  = (state_reg == ST_SNAP);
    assign ser_ready = tx_fire && ((state_reg == ST_HDR) || (state_reg == ST_DATA));

    dbg_byte_ser #(.N_WORDS(N_WORDS)) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .snap_data (snap_data),
        .out_data  (ser_data),
        .out_valid (ser_valid),
        .out_ready (ser_ready)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (cmd_fire) begin
                if (bus.cmd_byte == CMD_STEP)      state_next = ST_STEP;
                else if (bus.cmd_byte == CMD_RUN)  state_next = ST_RUN;
                else if (bus.cmd_byte == CMD_DUMP) state_next = ST_SNAP;
            end
            ST_RUN: if (cmd_fire) begin
                if (bus.cmd_byte == CMD_HALT)      state_next = ST_IDLE;
                else if (bus.cmd_byte == CMD_DUMP) state_next = ST_SNAP;
            end
            ST_STEP: state_next = ST_SNAP;
            ST_SNAP: state_next = ST_HDR;
            ST_HDR:  if (tx_fire) state_next = ST_DATA;
            // Serializer drained means the output register holds the final data byte.
            ST_DATA: if (tx_fire && !ser_valid) state_next = ST_CSUM;
            ST_CSUM: if (tx_fire) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cmd_ready_reg <= 1'b0;
            pipe_en_reg   <= 1'b0;
            tx_valid_reg  <= 1'b0;
            tx_data_reg   <= 8'h00;
            csum_reg      <= 8'h00;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= (state_next == ST_IDLE) || (state_next == ST_RUN);
            pipe_en_reg   <= (state_next == ST_RUN) || (state_next == ST_STEP);
            case (state_reg)
                ST_SNAP: begin
                    tx_valid_reg <= 1'b1;
                    tx_data_reg  <= HDR_BYTE;
                    csum_reg     <= 8'h00;
                end
                ST_HDR, ST_DATA: if (tx_fire) begin
                    if (ser_valid) tx_data_reg <= ser_data;
                    else           tx_data_reg <= csum_reg ^ tx_data_reg;
                    if (state_reg == ST_DATA) csum_reg <= csum_reg ^ tx_data_reg;
                end
                ST_CSUM: if (tx_fire) begin
                    tx_valid_reg <= 1'b0;
                    tx_data_reg  <= 8'h00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dumper.sv
// Directed bench for debug_dumper with two snapshot words; one task per scenario.
`timescale 1ns/1ps
module tb_debug_dumper;
    localparam int N_WORDS = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [32*N_WORDS-1:0] snap_data;
    logic                  pipe_en;
    logic                  busy;

    debug_dumper_if bus ();

    debug_dumper #(.N_WORDS(N_WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .snap_data (snap_data),
        .pipe_en   (pipe_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] exp_seq   [10];
    logic [7:0] got_bytes [10];
    int         got_n, stall_err, bubbles;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] b);
        bus.cmd_byte  = b;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Collects up to 10 transferred bytes, tracking stall stability and gaps.
    task automatic capture(input bit random_ready);
        int         cycles = 0;
        logic [7:0] held = 8'h00;
        bit         stalled;
        got_n = 0; stall_err = 0; bubbles = 0;
        for (int i = 0; i < 10; i++) got_bytes[i] = 8'hxx;
        while (got_n < 10 && cycles < 300) begin
            bus.tx_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (bus.tx_valid && bus.tx_ready) begin
                got_bytes[got_n] = bus.tx_data;
                got_n++;
            end else if (bus.tx_valid) begin
                held    = bus.tx_data;
                stalled = 1'b1;
            end else if (got_n > 0) begin
                bubbles++;
            end
            tick();
            if (stalled && (!bus.tx_valid || bus.tx_data !== held)) stall_err++;
            cycles++;
        end
        bus.tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        vectors++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", bus.cmd_ready); end
        vectors++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); end
        vectors++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h expected 00", bus.tx_data); end
        vectors++; if (pipe_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_pipe_busy: got %b%b expected 00", pipe_en, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL release_cmd_ready_early: got %b expected 0", bus.cmd_ready); end
        tick();
        vectors++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready: got %b expected 1", bus.cmd_ready); end
        $display("test_reset done");
    endtask

    task automatic test_dump();
        bus.tx_ready = 1'b1;
        issue(8'h44);
        vectors++; if (bus.tx_valid !== 1'b0 || busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL dump_snap_cycle: valid/busy/ready %b%b%b expected 010", bus.tx_valid, busy, bus.cmd_ready); end
        tick();
        vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
            errors++; $display("FAIL dump_latency: valid %b data %02h expected 1 a5", bus.tx_valid, bus.tx_data); end
        capture(1'b0);
        vectors++; if (got_n !== 10) begin errors++; $display("FAIL dump_count: got %0d expected 10", got_n); end
        for (int i = 0; i < 10; i++) begin
            vectors++; if (got_bytes[i] !== exp_seq[i]) begin errors++; $display("FAIL dump_byte%0d: got %02h expected %02h", i, got_bytes[i], exp_seq[i]); end
        end
        vectors++; if (bubbles !== 0) begin errors++; $display("FAIL dump_bubbles: got %0d expected 0", bubbles); end
        vectors++; if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL dump_end: busy %b valid %b expected 0 0", busy, bus.tx_valid); end
        $display("test_dump done: %0d bytes", got_n);
    endtask

    task automatic test_step();
        bus.tx_ready = 1'b1;
        issue(8'h53);
        vectors++; if (pipe_en !== 1'b1 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL step_pipe_on: pipe_en %b valid %b expected 1 0", pipe_en, bus.tx_valid); end
        tick();
        vectors++; if (pipe_en !== 1'b0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL step_pipe_off: pipe_en %b valid %b expected 0 0", pipe_en, bus.tx_valid); end
        tick();
        vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin errors++; $display("FAIL step_latency: valid %b data %02h expected 1 a5", bus.tx_valid, bus.tx_data); end
        snap_data = 64'hDEADBEEF_CAFEF00D;
        capture(1'b0);
        for (int i = 0; i < 10; i++) begin
            vectors++; if (got_bytes[i] !== exp_seq[i]) begin errors++; $display("FAIL step_byte%0d: got %02h expected %02h", i, got_bytes[i], exp_seq[i]); end
        end
        vectors++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL step_pipe_after: got %b expected 0", pipe_en); end
        snap_data = {32'h00000001, 32'h12345678};
        $display("test_step done: %0d bytes", got_n);
    endtask

    task automatic test_stall();
        issue(8'h44);
        capture(1'b1);
        vectors++; if (got_n !== 10) begin errors++; $display("FAIL stall_count: got %0d expected 10", got_n); end
        for (int i = 0; i < 10; i++) begin
            vectors++; if (got_bytes[i] !== exp_seq[i]) begin errors++; $display("FAIL stall_byte%0d: got %02h expected %02h", i, got_bytes[i], exp_seq[i]); end
        end
        vectors++; if (stall_err !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_err); end
        $display("test_stall done: %0d bytes", got_n);
    endtask

    task automatic test_run();
        int low = 0;
        vectors++; if (bus.cmd_ready !== 1'b1 || pipe_en !== 1'b0) begin errors++; $display("FAIL run_pre: ready %b pipe_en %b expected 1 0", bus.cmd_ready, pipe_en); end
        issue(8'h52);
        vectors++; if (pipe_en !== 1'b1 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL run_enter: pipe/busy/ready %b%b%b expected 101", pipe_en, busy, bus.cmd_ready); end
        repeat (20) begin
            tick();
            if (!pipe_en || bus.tx_valid) low++;
        end
        vectors++; if (low !== 0) begin errors++; $display("FAIL run_hold: got %0d bad cycles expected 0", low); end
        issue(8'h7A);
        vectors++; if (pipe_en !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL run_ignore: pipe/ready/valid %b%b%b expected 110", pipe_en, bus.cmd_ready, bus.tx_valid); end
        issue(8'h48);
        vectors++; if (pipe_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL run_halt: pipe_en %b busy %b expected 0 0", pipe_en, busy); end
        $display("test_run done");
    endtask

    task automatic test_reset_mid();
        int n_valid = 0;
        bus.tx_ready = 1'b1;
        issue(8'h44);
        tick();
        repeat (5) tick();
        vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL midrst_pre: valid %b data %02h expected 1 00", bus.tx_valid, bus.tx_data); end
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL midrst_async: valid %b busy %b data %02h expected 0 0 00", bus.tx_valid, busy, bus.tx_data); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        repeat (3) begin
            if (bus.tx_valid) n_valid++;
            tick();
        end
        vectors++; if (n_valid !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d valid cycles expected 0", n_valid); end
        vectors++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", bus.cmd_ready); end
        issue(8'h44);
        capture(1'b0);
        for (int i = 0; i < 10; i++) begin
            vectors++; if (got_bytes[i] !== exp_seq[i]) begin errors++; $display("FAIL midrst_byte%0d: got %02h expected %02h", i, got_bytes[i], exp_seq[i]); end
        end
        $display("test_reset_mid done: %0d bytes", got_n);
    endtask

    task automatic test_cmd_hold();
        int busy_cycles = 0;
        int ready_err = 0;
        int guard = 0;
        bus.tx_ready  = 1'b1;
        bus.cmd_byte  = 8'h44;
        bus.cmd_valid = 1'b1;
        tick();
        while (busy && guard < 50) begin
            busy_cycles++;
            if (bus.cmd_ready) ready_err++;
            tick();
            guard++;
        end
        vectors++; if (busy_cycles !== 11) begin errors++; $display("FAIL hold_busy_len: got %0d expected 11", busy_cycles); end
        vectors++; if (ready_err !== 0) begin errors++; $display("FAIL hold_ready_low: got %0d ready cycles expected 0", ready_err); end
        vectors++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL hold_idle_ready: got %b expected 1", bus.cmd_ready); end
        tick();
        bus.cmd_valid = 1'b0;
        vectors++; if (busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_accept: busy %b ready %b expected 1 0", busy, bus.cmd_ready); end
        capture(1'b0);
        vectors++; if (got_n !== 10 || got_bytes[9] !== 8'h09) begin errors++; $display("FAIL hold_second_dump: count %0d csum %02h expected 10 09", got_n, got_bytes[9]); end
        $display("test_cmd_hold done: busy %0d cycles", busy_cycles);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_seq = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h01, 8'h09};
        snap_data     = {32'h00000001, 32'h12345678};
        bus.cmd_byte  = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.tx_ready  = 1'b1;
        test_reset();
        test_dump();
        test_step();
        test_stall();
        test_run();
        test_reset_mid();
        test_cmd_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/debug_dumper.md
DEBUG_DUMPER -- requirements
Module: debug_dumper

Interface
REQ-001 SHALL have parameter: N_WORDS, 8, number of 32-bit pipeline words per dump (1..64).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; it is asynchronous and active-low.
REQ-004 SHALL have ports: cmd_byte  input  8  host command byte; cmd_valid  input  1  command present; cmd_ready  output  1  command accepted when valid&ready.
REQ-005 SHALL have port: snap_data  input  32*N_WORDS  pipeline state words; word k at bits [32k+31:32k].
REQ-006 SHALL have ports: tx_data  output  8  dump byte; tx_valid  output  1  byte present; tx_ready  input  1  downstream (UART TX) accepts.
REQ-007 SHALL have ports: pipe_en  output  1  pipeline clock enable; busy  output  1  high in any state except IDLE and RUN.

Function
REQ-008 SHALL implement states IDLE, RUN, STEP, SNAP, HDR, DATA, CSUM.
REQ-009 SHALL assert cmd_ready only in IDLE and RUN; a command transfers on a clock edge with cmd_valid&cmd_ready.
REQ-010 SHALL decode in IDLE: 0x53 'S' -> STEP; 0x52 'R' -> RUN; 0x44 'D' -> SNAP; other bytes are consumed with no effect.
REQ-011 SHALL decode in RUN: 0x48 'H' -> IDLE; 0x44 'D' -> SNAP; other bytes are consumed with no effect.
REQ-012 SHALL drive pipe_en high in RUN and STEP only; STEP lasts exactly one cycle, then goes to SNAP.
REQ-013 SHALL, in SNAP (one cycle), register all of snap_data into an internal snapshot, then go to HDR. The snapshot is stable for the whole dump.
REQ-014 SHALL, in HDR, present tx_data=0xA5 with tx_valid=1.
REQ-015 SHALL, in DATA, send N_WORDS*4 bytes: word 0 first, MSB first within each word.
REQ-016 SHALL, in CSUM, send the XOR of all DATA bytes (header excluded), then return to IDLE; a dump started from RUN also returns to IDLE.
REQ-017 SHALL hold tx_data and tx_valid stable until tx_ready; one byte transfers per cycle with tx_valid&tx_ready; back-to-back transfers have no bubble.
REQ-018 SHALL drive tx_valid from a register, with no combinational path from tx_ready or cmd_valid to tx_valid.
REQ-019 SHALL compute byte indices with wrap-free counters sized clog2(N_WORDS*4); the final index SHALL transition to CSUM, never to index 0.
REQ-020 SHALL give latency from an accepted 'D' to first tx_valid of exactly 2 cycles, and from 'S' of exactly 3 cycles.

Reset
REQ-021 SHALL, on rst_n low, immediately set state=IDLE and clear cmd_ready, tx_valid, tx_data=0x00, pipe_en, busy, counters, checksum and snapshot; cmd_ready rises the first edge after release.
REQ-022 SHALL, if reset asserts mid-dump, abandon the dump with no further bytes; the next dump restarts from the header.

Structure
REQ-023 SHALL place in shared package debug_pkg: command codes (0x53, 0x52, 0x48, 0x44), header constant 0xA5, and the state enum.
REQ-024 SHALL use one sub-module, dbg_byte_ser: snapshot register plus MSB-first byte mux/counter with valid/ready output; FSM and checksum stay in debug_dumper.

Verification (bench uses N_WORDS=2, word0=0x12345678, word1=0x00000001)
REQ-025 SHALL cover: 'D' from IDLE with tx_ready=1 -> bytes A5 12 34 56 78 00 00 00 01 09 on consecutive cycles; busy low afterwards.
REQ-026 SHALL cover: 'S' -> pipe_en high exactly 1 cycle, first byte 3 cycles after accept; snap_data changed during dump -> transmitted bytes unchanged.
REQ-027 SHALL cover: tx_ready toggled 1/0 randomly during dump -> tx_data stable while stalled; same 10-byte sequence.
REQ-028 SHALL cover: 'R', 20 idle cycles, 'H' -> pipe_en high exactly from accept+1 through the 'H' accept edge; 0x7A in RUN -> ignored, pipe_en stays high.
REQ-029 SHALL cover: rst_n pulsed low after 4th DATA byte -> tx_valid=0 at once; a new 'D' -> sequence restarts at A5.
REQ-030 SHALL cover: cmd_valid held high during a dump -> cmd_ready=0 until IDLE; command accepted on the first IDLE cycle.
